// File: rtl/mmc1_mapper.sv
// mmc1_mapper: MMC1-style bank mapper for a cartridge bus.
//
// Serial register interface: the CPU writes one bit at a time (data[0]) into
// a 5-bit shift register through $8000-$FFFF. On the fifth accepted write,
// the assembled value lands in the register picked by cpu_addr[14:13].
// Writing with data[7] set aborts the sequence and forces 16 KB PRG mode
// with the last bank fixed at $C000.
//
// Ports:
//   clk, rst_n         CPU bus clock, async active-low reset
//   m2                 CPU phase-2 qualifier (gates PRG RAM select)
//   cpu_addr[14:0]     CPU address; romsel marks $8000-$FFFF
//   cpu_data_i[7:0]    CPU write data; cpu_rw 1 = read, 0 = write
//   ppu_addr[13:0]     PPU address; ppu_wr PPU write strobe
//   prg_addr           PRG ROM byte address
//   prg_ram_ce/_we     PRG RAM ($6000-$7FFF) select / write enable
//   chr_addr, chr_we   CHR byte address / CHR RAM write enable
//   ciram_ce, ciram_a10  nametable VRAM select and A10
module mmc1_mapper #(
    parameter int PRG_ADDR_W = 18,
    parameter int CHR_ADDR_W = 17,
    parameter int CHR_RAM    = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m2,
    input  logic [14:0]           cpu_addr,
    input  logic [7:0]            cpu_data_i,
    input  logic                  cpu_rw,
    input  logic                  romsel,
    input  logic [13:0]           ppu_addr,
    input  logic                  ppu_wr,
    output logic [PRG_ADDR_W-1:0] prg_addr,
    output logic                  prg_ram_ce,
    output logic                  prg_ram_we,
    output logic [CHR_ADDR_W-1:0] chr_addr,
    output logic                  chr_we,
    output logic                  ciram_ce,
    output logic                  ciram_a10
);

    logic [4:0]  shift;
    logic [4:0]  control;
    logic [4:0]  chr0;
    logic [4:0]  chr1;
    logic [4:0]  prg;
    logic        wr_q;
    logic        wr;
    logic        wr_accept;
    logic [4:0]  shift_next;
    logic [3:0]  prg_bank;
    logic [17:0] prg_full;
    logic [16:0] chr_full;
    logic        unused_data;

    assign unused_data = ^cpu_data_i[6:1];

    assign wr         = romsel & ~cpu_rw;
    // A write on the cycle right after another write (RMW dummy write) is dropped.
    assign wr_accept  = wr & ~wr_q;
    assign shift_next = {cpu_data_i[0], shift[4:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift   <= 5'b10000;
            control <= 5'b01100;
            chr0    <= '0;
            chr1    <= '0;
            prg     <= '0;
            wr_q    <= 1'b0;
        end else begin
            wr_q <= wr;
            if (wr_accept) begin
                if (cpu_data_i[7]) begin
                    shift   <= 5'b10000;
                    control <= control | 5'b01100;
                end else if (!shift[0]) begin
                    shift <= shift_next;
                end else begin
                    // Marker bit reached shift[0]: this is the fifth write.
                    case (cpu_addr[14:13])
                        2'b00:   control <= shift_next;
                        2'b01:   chr0    <= shift_next;
                        2'b10:   chr1    <= shift_next;
                        default: prg     <= shift_next;
                    endcase
                    shift <= 5'b10000;
                end
            end
        end
    end

    always_comb begin
        prg_bank = '0;
        prg_full = '0;
        if (!control[3]) begin
            prg_full = {prg[3:1], cpu_addr};
        end else begin
            if (control[2]) begin
                prg_bank = cpu_addr[14] ? 4'hF : prg[3:0];
            end else begin
                prg_bank = cpu_addr[14] ? prg[3:0] : 4'h0;
            end
            prg_full = {prg_bank, cpu_addr[13:0]};
        end
    end

    always_comb begin
        chr_full = '0;
        if (control[4]) begin
            chr_full = {(ppu_addr[12] ? chr1 : chr0), ppu_addr[11:0]};
        end else begin
            chr_full = {chr0[4:1], ppu_addr[12:0]};
        end
    end

    always_comb begin
        ciram_a10 = 1'b0;
        case (control[1:0])
            2'd0:    ciram_a10 = 1'b0;
            2'd1:    ciram_a10 = 1'b1;
            2'd2:    ciram_a10 = ppu_addr[10];
            default: ciram_a10 = ppu_addr[11];
        endcase
    end

    // Bank bits beyond the physical address width are dropped from the top.
    if (PRG_ADDR_W <= 18) begin : g_prg_trunc
        assign prg_addr = prg_full[PRG_ADDR_W-1:0];
    end else begin : g_prg_ext
        assign prg_addr = {{(PRG_ADDR_W-18){1'b0}}, prg_full};
    end

    if (CHR_ADDR_W <= 17) begin : g_chr_trunc
        assign chr_addr = chr_full[CHR_ADDR_W-1:0];
    end else begin : g_chr_ext
        assign chr_addr = {{(CHR_ADDR_W-17){1'b0}}, chr_full};
    end

    assign ciram_ce   = ppu_addr[13];
    assign prg_ram_ce = m2 & ~romsel & (cpu_addr[14:13] == 2'b11) & ~prg[4];
    assign prg_ram_we = prg_ram_ce & ~cpu_rw;
    assign chr_we     = (CHR_RAM != 0) & ppu_wr & ~ppu_addr[13];

endmodule

// File: tb/tb_mmc1_mapper.sv
module tb_mmc1_mapper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m2 = 1'b1;
    logic [14:0] cpu_addr = '0;
    logic [7:0]  cpu_data_i = '0;
    logic        cpu_rw = 1'b1;
    logic        romsel = 1'b0;
    logic [13:0] ppu_addr = '0;
    logic        ppu_wr = 1'b0;
    logic [17:0] prg_addr;
    logic        prg_ram_ce;
    logic        prg_ram_we;
    logic [16:0] chr_addr;
    logic        chr_we;
    logic        ciram_ce;
    logic        ciram_a10;

    int n_tests = 0;
    int n_fail  = 0;

    mmc1_mapper #(
        .PRG_ADDR_W(18),
        .CHR_ADDR_W(17),
        .CHR_RAM(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .m2(m2),
        .cpu_addr(cpu_addr),
        .cpu_data_i(cpu_data_i),
        .cpu_rw(cpu_rw),
        .romsel(romsel),
        .ppu_addr(ppu_addr),
        .ppu_wr(ppu_wr),
        .prg_addr(prg_addr),
        .prg_ram_ce(prg_ram_ce),
        .prg_ram_we(prg_ram_we),
        .chr_addr(chr_addr),
        .chr_we(chr_we),
        .ciram_ce(ciram_ce),
        .ciram_a10(ciram_a10)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] a;
        logic        rs;
        logic        rw;
        logic        m2;
        logic [13:0] pa;
        logic        pw;
        logic [17:0] e_prg;
        logic        e_ce;
        logic        e_we;
        logic [16:0] e_chr;
        logic        e_cwe;
        logic        e_cce;
        logic        e_a10;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        romsel = 1'b0;
        cpu_rw = 1'b1;
        cpu_addr = '0;
        cpu_data_i = '0;
    endtask

    // Single CPU write followed by an idle cycle so consecutive calls never
    // look like back-to-back writes.
    task automatic cpu_write(input logic [14:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_addr = a; cpu_data_i = d; romsel = 1'b1; cpu_rw = 1'b0;
        @(negedge clk);
        idle();
    endtask

    // Five serial writes, bit 0 of val first.
    task automatic load5(input logic [14:0] a, input logic [4:0] val);
        for (int unsigned i = 0; i < 5; i++) begin
            cpu_write(a, {7'b0, val[i]});
        end
    endtask

    task automatic probe(input logic [14:0] a, input logic rs, input logic rw,
                         input logic mm, input logic [13:0] pa);
        @(negedge clk);
        cpu_addr = a; romsel = rs; cpu_rw = rw; m2 = mm; ppu_addr = pa; ppu_wr = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #6 idle();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{15'h7FFC, 1'b1, 1'b1, 1'b1, 14'h0000, 1'b0, 18'h3FFFC, 1'b0, 1'b0, 17'h00000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{15'h0000, 1'b1, 1'b1, 1'b1, 14'h2400, 1'b1, 18'h00000, 1'b0, 1'b0, 17'h00400, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{15'h4123, 1'b1, 1'b1, 1'b0, 14'h1ABC, 1'b1, 18'h3C123, 1'b0, 1'b0, 17'h01ABC, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{15'h3FFF, 1'b1, 1'b1, 1'b1, 14'h3FFF, 1'b0, 18'h03FFF, 1'b0, 1'b0, 17'h01FFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{15'h6000, 1'b0, 1'b1, 1'b1, 14'h0800, 1'b0, 18'h3E000, 1'b1, 1'b0, 17'h00800, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{15'h7FFF, 1'b0, 1'b0, 1'b1, 14'h2C00, 1'b1, 18'h3FFFF, 1'b1, 1'b1, 17'h00C00, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{15'h6000, 1'b0, 1'b0, 1'b0, 14'h0000, 1'b0, 18'h3E000, 1'b0, 1'b0, 17'h00000, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{15'h6000, 1'b1, 1'b1, 1'b1, 14'h0000, 1'b0, 18'h3E000, 1'b0, 1'b0, 17'h00000, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{15'h4000, 1'b0, 1'b0, 1'b1, 14'h1000, 1'b1, 18'h3C000, 1'b0, 1'b0, 17'h01000, 1'b1, 1'b0, 1'b0};

        idle();
        do_reset();

        // Power-on state: all combinational outputs against the table.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            cpu_addr = vecs[i].a; romsel = vecs[i].rs; cpu_rw = vecs[i].rw;
            m2 = vecs[i].m2; ppu_addr = vecs[i].pa; ppu_wr = vecs[i].pw;
            #1;
            check($sformatf("v%0d prg_addr", i), 32'(prg_addr), 32'(vecs[i].e_prg));
            check($sformatf("v%0d prg_ram_ce", i), 32'(prg_ram_ce), 32'(vecs[i].e_ce));
            check($sformatf("v%0d prg_ram_we", i), 32'(prg_ram_we), 32'(vecs[i].e_we));
            check($sformatf("v%0d chr_addr", i), 32'(chr_addr), 32'(vecs[i].e_chr));
            check($sformatf("v%0d chr_we", i), 32'(chr_we), 32'(vecs[i].e_cwe));
            check($sformatf("v%0d ciram_ce", i), 32'(ciram_ce), 32'(vecs[i].e_cce));
            check($sformatf("v%0d ciram_a10", i), 32'(ciram_a10), 32'(vecs[i].e_a10));
        end
        @(negedge clk);
        idle(); ppu_wr = 1'b0; m2 = 1'b1;

        // PRG bank 5 in 16 KB switchable-$8000 mode.
        load5(15'h6000, 5'b00101);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h0000);
        check("prg5 $8000", 32'(prg_addr), 32'h14000);
        probe(15'h4000, 1'b1, 1'b1, 1'b1, 14'h0000);
        check("prg5 $C000", 32'(prg_addr), 32'h3C000);

        // control = 00010: vertical mirroring, 32 KB PRG.
        load5(15'h0000, 5'b00010);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h2400);
        check("vert a10 2400", 32'(ciram_a10), 32'h1);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h2800);
        check("vert a10 2800", 32'(ciram_a10), 32'h0);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h0000);
        check("32k $8000", 32'(prg_addr), 32'h10000);
        probe(15'h7FFC, 1'b1, 1'b1, 1'b1, 14'h0000);
        check("32k $FFFC", 32'(prg_addr), 32'h17FFC);

        // Two partial writes, then bit-7 abort: control |= 01100.
        cpu_write(15'h0000, 8'h01);
        cpu_write(15'h0000, 8'h01);
        cpu_write(15'h2000, 8'h80);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h2400);
        check("abort $8000", 32'(prg_addr), 32'h14000);
        check("abort a10 kept", 32'(ciram_a10), 32'h1);
        probe(15'h4000, 1'b1, 1'b1, 1'b1, 14'h0000);
        check("abort $C000", 32'(prg_addr), 32'h3C000);
        load5(15'h6000, 5'b00110);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h0000);
        check("fresh load prg6", 32'(prg_addr), 32'h18000);

        // Horizontal mirroring with 4 KB CHR banks.
        load5(15'h0000, 5'b11111);
        load5(15'h2000, 5'b00011);
        load5(15'h4000, 5'b10101);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h2800);
        check("horiz a10 2800", 32'(ciram_a10), 32'h1);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h2400);
        check("horiz a10 2400", 32'(ciram_a10), 32'h0);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h0123);
        check("chr4k lo", 32'(chr_addr), 32'h03123);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h1456);
        check("chr4k hi", 32'(chr_addr), 32'h15456);

        // Back to 8 KB CHR: chr0 bit 0 is ignored.
        load5(15'h0000, 5'b01100);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h1ABC);
        check("chr8k", 32'(chr_addr), 32'h03ABC);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h2C00);
        check("onescreen a10", 32'(ciram_a10), 32'h0);

        // Reset mid-sequence, then a back-to-back pair (second dropped).
        cpu_write(15'h6000, 8'h01);
        cpu_write(15'h6000, 8'h01);
        do_reset();
        probe(15'h4000, 1'b1, 1'b1, 1'b1, 14'h0000);
        check("rst $C000", 32'(prg_addr), 32'h3C000);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h0000);
        check("rst $8000", 32'(prg_addr), 32'h00000);
        @(negedge clk);
        cpu_addr = 15'h6000; cpu_data_i = 8'h01; romsel = 1'b1; cpu_rw = 1'b0;
        @(negedge clk);
        cpu_data_i = 8'h01;
        @(negedge clk);
        idle();
        for (int unsigned i = 0; i < 4; i++) cpu_write(15'h6000, 8'h00);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h0000);
        check("rmw prg1", 32'(prg_addr), 32'h04000);

        // prg[4] disables PRG RAM.
        do_reset();
        load5(15'h6000, 5'b10000);
        probe(15'h6000, 1'b0, 1'b0, 1'b1, 14'h0000);
        check("ram dis ce", 32'(prg_ram_ce), 32'h0);
        check("ram dis we", 32'(prg_ram_we), 32'h0);
        probe(15'h0000, 1'b1, 1'b1, 1'b1, 14'h0000);
        check("prg16 $8000", 32'(prg_addr), 32'h00000);

        @(negedge clk);
        idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
